// File: rtl/spi_nor_pkg.sv
// Shared definitions for the SPI NOR word-read path: default widths,
// the flash read opcode and the arbiter FSM state encoding.
package spi_nor_pkg;

    localparam int         SPI_NOR_ADDR_W = 22;
    localparam int         SPI_NOR_DATA_W = 32;
    localparam logic [7:0] NOR_READ_CMD   = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HIT      = 3'd1,
        ST_MEM_REQ  = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_RESP     = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: picks the first requesting index at or after the
// pointer (modulo NUM_REQ); the pointer moves past the winner on en.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic               gnt_any,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [IDX_W-1:0]   rr_ptr
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Search distances from farthest to nearest so the nearest request wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && (((int'(ptr_q) + k) % NUM_REQ) == i)) begin
                    gnt_any = 1'b1;
                    gnt_idx = IDX_W'(i);
                end
            end
        end
    end

    // Next pointer is one past the granted index, wrapping at NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (en && gnt_any) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign rr_ptr = ptr_q;

endmodule

// File: rtl/spi_nor_arbiter.sv
// Shares one spi_nor_flash word-read port between NUM_REQ requesters with
// round-robin arbitration and a single-entry last-word buffer.
module spi_nor_arbiter
    import spi_nor_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = SPI_NOR_ADDR_W,
    parameter  int DATA_W  = SPI_NOR_DATA_W,
    parameter  int HIT_BUF = 1,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         req_data,
    input  logic                      invalidate,
    output logic                      mem_valid,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_data,
    output logic                      busy
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0]  buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]  buf_data_q, buf_data_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [DATA_W-1:0]  req_data_q, req_data_d;
    logic               mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;

    logic               arb_en;
    logic               arb_any;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   arb_ptr;
    logic [ADDR_W-1:0]  sel_addr;
    logic [NUM_REQ-1:0] gnt_onehot;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req_valid),
        .en      (arb_en),
        .gnt_any (arb_any),
        .gnt_idx (arb_idx),
        .rr_ptr  (arb_ptr)
    );

    // Address of the requester the arbiter currently favours.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign gnt_onehot = NUM_REQ'(1) << gnt_q;

    // FSM next state and datapath updates. A grant is withheld while a
    // completion pulse is showing so the requester can drop valid first.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        req_ready_d = '0;
        req_data_d  = req_data_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        arb_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any && (req_ready_q == '0)) begin
                    arb_en = 1'b1;
                    gnt_d  = arb_idx;
                    addr_d = sel_addr;
                    if ((HIT_BUF != 0) && buf_valid_q && (buf_addr_q == sel_addr) && !invalidate)
                        state_d = ST_HIT;
                    else
                        state_d = ST_MEM_REQ;
                end
            end
            ST_HIT: begin
                req_ready_d = gnt_onehot;
                req_data_d  = buf_data_q;
                state_d     = ST_IDLE;
            end
            ST_MEM_REQ: begin
                mem_valid_d = 1'b1;
                mem_addr_d  = addr_q;
                state_d     = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    buf_addr_d  = addr_q;
                    buf_data_d  = mem_data;
                    buf_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                req_ready_d = gnt_onehot;
                req_data_d  = buf_data_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Invalidate overrides any fill in the same cycle.
        if (invalidate) buf_valid_d = 1'b0;
    end

    // State, grant and buffer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            addr_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            req_ready_q <= '0;
            req_data_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            req_ready_q <= req_ready_d;
            req_data_q  <= req_data_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_data  = req_data_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
